// File: rtl/calc_pkg.sv
// Shared definitions for the UART calculator sequencer: state codes, ALU opcodes,
// default framing characters and the ASCII operator decoder.
package calc_pkg;

  typedef enum logic [7:0] {
    StA    = 8'h01,
    StB    = 8'h02,
    StExec = 8'h04,
    StTxr  = 8'h08,
    StTxc  = 8'h10,
    StTxe  = 8'h20
  } state_e;

  localparam int unsigned OpW = 6;

  localparam logic [OpW-1:0] OP_ADD = 6'b100000;
  localparam logic [OpW-1:0] OP_SUB = 6'b100010;
  localparam logic [OpW-1:0] OP_AND = 6'b100100;
  localparam logic [OpW-1:0] OP_OR  = 6'b100101;
  localparam logic [OpW-1:0] OP_XOR = 6'b100110;
  localparam logic [OpW-1:0] OP_NOR = 6'b100111;

  localparam logic [7:0] CR_CHAR_DEF  = 8'h0D;
  localparam logic [7:0] ERR_CHAR_DEF = 8'h3F;

  typedef struct packed {
    logic           valid;
    logic [OpW-1:0] op;
  } op_dec_t;

  function automatic op_dec_t ascii_to_op(input logic [7:0] c);
    op_dec_t d;
    d.valid = 1'b1;
    d.op    = OP_ADD;
    case (c)
      8'h2B:   d.op = OP_ADD;  // '+'
      8'h2D:   d.op = OP_SUB;  // '-'
      8'h26:   d.op = OP_AND;  // '&'
      8'h7C:   d.op = OP_OR;   // '|'
      8'h5E:   d.op = OP_XOR;  // '^'
      8'h7E:   d.op = OP_NOR;  // '~'
      default: begin
        d.valid = 1'b0;
        d.op    = '0;
      end
    endcase
    return d;
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

endpackage

// File: rtl/calc_operand_acc.sv
// Decimal operand accumulator: value <= value*10 + digit (wrapping), plus a flag
// recording that at least one digit has been seen since the last clear.
module calc_operand_acc #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load_digit,
  input  logic [3:0]        digit,
  output logic [DATA_W-1:0] value,
  output logic              seen
);

  logic [DATA_W-1:0] value_q, value_d;
  logic              seen_q, seen_d;

  always_comb begin
    value_d = value_q;
    seen_d  = seen_q;
    if (clear) begin
      value_d = '0;
      seen_d  = 1'b0;
    end else if (load_digit) begin
      value_d = value_q * DATA_W'(10) + DATA_W'(digit);
      seen_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      seen_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      seen_q  <= seen_d;
    end
  end

  assign value = value_q;
  assign seen  = seen_q;

endmodule

// File: rtl/uart_calc_sequencer.sv
// Parses "A op B CR" from the UART receiver, drives the external ALU, then sends
// the result byte followed by CR (or '?' on a parse error) through the transmitter.
module uart_calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned OP_W     = 6,
  parameter logic [7:0]  CR_CHAR  = CR_CHAR_DEF,
  parameter logic [7:0]  ERR_CHAR = ERR_CHAR_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  input  logic              tx_done,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic [7:0]        LEDS,
  output logic [7:0]        STATE
);

  state_e          state_q, state_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [7:0]      leds_q, leds_d;

  logic    a_load, b_load, acc_clear;
  logic    a_seen, b_seen;
  logic    rx_ok, rx_digit;
  op_dec_t dec;

  // A received byte coinciding with tx_done is dropped in favour of the TX handshake.
  assign rx_ok    = rx_done & ~tx_done;
  assign rx_digit = is_digit(rx_data);
  assign dec      = ascii_to_op(rx_data);

  calc_operand_acc #(
    .DATA_W(DATA_W)
  ) u_acc_a (
    .clk       (CLK),
    .rst       (RESET),
    .clear     (acc_clear),
    .load_digit(a_load),
    .digit     (rx_data[3:0]),
    .value     (alu_a),
    .seen      (a_seen)
  );

  calc_operand_acc #(
    .DATA_W(DATA_W)
  ) u_acc_b (
    .clk       (CLK),
    .rst       (RESET),
    .clear     (acc_clear),
    .load_digit(b_load),
    .digit     (rx_data[3:0]),
    .value     (alu_b),
    .seen      (b_seen)
  );

  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    op_d       = op_q;
    leds_d     = leds_q;
    a_load     = 1'b0;
    b_load     = 1'b0;
    acc_clear  = 1'b0;

    case (state_q)
      StA: begin
        if (rx_ok) begin
          if (rx_digit) begin
            a_load = 1'b1;
          end else if (dec.valid && a_seen) begin
            op_d    = OP_W'(dec.op);
            state_d = StB;
          end else begin
            tx_data_d  = ERR_CHAR;
            tx_start_d = 1'b1;
            state_d    = StTxe;
          end
        end
      end
      StB: begin
        if (rx_ok) begin
          if (rx_digit) begin
            b_load = 1'b1;
          end else if ((rx_data == CR_CHAR) && b_seen) begin
            state_d = StExec;
          end else begin
            tx_data_d  = ERR_CHAR;
            tx_start_d = 1'b1;
            state_d    = StTxe;
          end
        end
      end
      StExec: begin
        // Operands and opcode have been stable for a full cycle; capture the ALU.
        leds_d     = 8'(alu_result);
        tx_data_d  = 8'(alu_result);
        tx_start_d = 1'b1;
        state_d    = StTxr;
      end
      StTxr: begin
        if (tx_done) begin
          tx_data_d  = CR_CHAR;
          tx_start_d = 1'b1;
          state_d    = StTxc;
        end
      end
      StTxc, StTxe: begin
        if (tx_done) begin
          acc_clear = 1'b1;
          op_d      = '0;
          state_d   = StA;
        end
      end
      default: begin
        acc_clear = 1'b1;
        op_d      = '0;
        state_d   = StA;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= StA;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      op_q       <= '0;
      leds_q     <= '0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      op_q       <= op_d;
      leds_q     <= leds_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign alu_op   = op_q;
  assign LEDS     = leds_q;
  assign STATE    = state_q;

endmodule
